// File: rtl/cp0_unit.sv
// cp0_unit: Coprocessor-0 Status/Cause/EPC registers, interrupt capture and exception/eret sequencer.
// Inputs: in_clk, in_rst_n, commit strobes (in_valid, in_syscall, in_mfc0, in_mtc0, in_eret), in_rd, in_wdata, in_next_pc, in_irq.
// Outputs: out_rdata (comb read port), out_redirect/out_target (one-cycle fetch redirect), out_int_ack, out_ie, out_epc.
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0800,
  parameter int          NIRQ       = 3
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  input  logic            in_valid,
  input  logic            in_syscall,
  input  logic            in_mfc0,
  input  logic            in_mtc0,
  input  logic            in_eret,
  input  logic [4:0]      in_rd,
  input  logic [31:0]     in_wdata,
  input  logic [31:0]     in_next_pc,
  input  logic [NIRQ-1:0] in_irq,
  output logic [31:0]     out_rdata,
  output logic            out_redirect,
  output logic [31:0]     out_target,
  output logic [NIRQ-1:0] out_int_ack,
  output logic            out_ie,
  output logic [31:0]     out_epc
);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t          state, state_next;
  logic            ie, ie_next;
  logic [NIRQ-1:0] im, im_next;
  logic [NIRQ-1:0] ip, ip_next;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] ack, ack_next;
  logic [4:0]      exc, exc_next;
  logic [31:0]     epc, epc_next;
  logic [31:0]     target, target_next;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] int_sel;
  logic            live;
  logic [31:0]     status_word, cause_word;

  // mfc0 needs no qualification: the read port is always live.
  logic unused_mfc0;
  assign unused_mfc0 = in_mfc0;

  assign pending = ip & im;
  // Strobes are squashed while the redirect is in flight.
  assign live    = (state == IDLE) && in_valid;

  // Highest-numbered pending unmasked line wins (later iterations override).
  always_comb begin
    int_sel = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (pending[i]) begin
        int_sel    = '0;
        int_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = IDLE;
    ie_next     = ie;
    im_next     = im;
    ip_next     = ip;
    exc_next    = exc;
    epc_next    = epc;
    target_next = target;
    ack_next    = '0;

    // mtc0 lands first so that an exception entry below overrides IE/EPC.
    if (live && in_mtc0) begin
      case (in_rd)
        5'd12: begin
          ie_next = in_wdata[0];
          im_next = in_wdata[8 +: NIRQ];
        end
        5'd13:   ip_next = ip & in_wdata[8 +: NIRQ];  // software may only clear
        5'd14:   epc_next = in_wdata;
        default: ;
      endcase
    end

    if (live && in_eret) begin
      ie_next     = 1'b1;
      target_next = epc;
      state_next  = REDIR;
    end else if (live && in_syscall) begin
      epc_next    = in_next_pc;
      exc_next    = 5'd8;
      ie_next     = 1'b0;
      target_next = EXC_VECTOR;
      state_next  = REDIR;
    end else if (live && ie && (|pending)) begin
      epc_next    = in_next_pc;
      exc_next    = 5'd0;
      ie_next     = 1'b0;
      ip_next     = ip_next & ~int_sel;
      ack_next    = int_sel;
      target_next = EXC_VECTOR;
      state_next  = REDIR;
    end

    // New edges are captured in every state and never lost to a clear.
    ip_next = ip_next | (in_irq & ~irq_q);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state  <= IDLE;
      ie     <= 1'b0;
      im     <= '1;
      ip     <= '0;
      irq_q  <= '0;
      exc    <= 5'd0;
      epc    <= 32'h0;
      target <= 32'h0;
      ack    <= '0;
    end else begin
      state  <= state_next;
      ie     <= ie_next;
      im     <= im_next;
      ip     <= ip_next;
      irq_q  <= in_irq;
      exc    <= exc_next;
      epc    <= epc_next;
      target <= target_next;
      ack    <= ack_next;
    end
  end

  always_comb begin
    status_word              = 32'h0;
    status_word[0]           = ie;
    status_word[8 +: NIRQ]   = im;
    cause_word               = 32'h0;
    cause_word[6:2]          = exc;
    cause_word[8 +: NIRQ]    = ip;
  end

  always_comb begin
    case (in_rd)
      5'd12:   out_rdata = status_word;
      5'd13:   out_rdata = cause_word;
      5'd14:   out_rdata = epc;
      default: out_rdata = 32'h0;
    endcase
  end

  // Decoded from the state register so reset drops it without waiting for a clock.
  assign out_redirect = (state == REDIR);
  assign out_target   = target;
  assign out_int_ack  = ack;
  assign out_ie       = ie;
  assign out_epc      = epc;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Coprocessor-0 and exception sequencer that sits directly downstream of the instruction control decoder. It consumes the decoder's syscall, mfc0, mtc0 and eret strobes together with the committing instruction's PC. It holds the Status, Cause and EPC registers, latches external interrupt requests, and issues a one-cycle PC redirect to the fetch mux on exception entry and on eret.

Parameters:
EXC_VECTOR, 32'h0000_0800, handler entry address loaded into PC on any exception.
NIRQ, 3, number of external interrupt lines (1..5).

Ports:
in_clk  input  1  system clock, rising edge.
in_rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  an instruction commits this cycle; strobes are ignored when low.
in_syscall  input  1  decoder syscall strobe.
in_mfc0  input  1  decoder mfc0 strobe.
in_mtc0  input  1  decoder mtc0 strobe.
in_eret  input  1  decoder eret strobe.
in_rd  input  5  CP0 register number (instruction rd field).
in_wdata  input  32  rt value for mtc0.
in_next_pc  input  32  PC that would follow the committing instruction.
in_irq  input  NIRQ  external interrupt lines, level, asynchronous to nothing (same clock).
out_rdata  output  32  CP0 read data for mfc0.
out_redirect  output  1  one-cycle pulse: fetch must load out_target.
out_target  output  32  redirect address.
out_int_ack  output  NIRQ  one-hot pulse: interrupt line accepted.
out_ie  output  1  Status.IE.
out_epc  output  32  current EPC.

Behaviour:
- Registers:
  - Status (rd=12): bit0 IE, bits[8+NIRQ-1:8] IM mask. Other bits read 0.
  - Cause (rd=13): bits[6:2] ExcCode, bits[8+NIRQ-1:8] IP pending. Other bits read 0.
  - EPC (rd=14): 32 bits.
- Reset (async, in_rst_n=0): IE=0, IM=all 1, IP=0, ExcCode=0, EPC=0, state=IDLE. Outputs: out_redirect=0, out_target=0, out_int_ack=0, out_rdata reflects the reset registers.
- out_rdata is combinational from in_rd. rd values other than 12/13/14 read 32'h0. Reading is not gated by in_mfc0.
- IP capture: each in_irq bit is registered once. A rising edge (prev=0, cur=1) sets the matching IP bit. The IP bit clears only when that line is accepted, or when mtc0 to Cause writes 0 to it. mtc0 writing 1 to an IP bit has no effect.
- mtc0 (in_valid & in_mtc0):
  - rd=12 writes IE and IM.
  - rd=14 writes EPC.
  - rd=13 affects only IP, as above.
  - Any other rd is ignored.
- States:
  - IDLE: evaluate events. Accepted event → REDIR at the next edge.
  - REDIR: out_redirect=1 for exactly this cycle; in_valid and all strobes are ignored (CPU squashes). Next state is IDLE.
- Event priority in IDLE, evaluated using register values before any same-cycle mtc0 write:
  1. in_valid & in_eret: IE←1, target←EPC.
  2. in_valid & in_syscall: EPC←in_next_pc, ExcCode←8, IE←0, target←EXC_VECTOR.
  3. Interrupt: requires in_valid, IE=1, (IP & IM) ≠ 0, and no eret or syscall this cycle. Take the highest-numbered pending unmasked line. EPC←in_next_pc, ExcCode←0, IE←0, clear that IP bit, target←EXC_VECTOR. out_int_ack one-hot is asserted during the REDIR cycle.
  4. If mtc0 coincides with an accepted interrupt, the mtc0 write still lands. For fields the interrupt entry also modifies (IE, EPC), the interrupt entry wins.
- out_target holds its last value outside REDIR.
- Reset asserted during REDIR aborts the redirect immediately.
- An irq edge arriving during REDIR is still captured in IP.

Test Plan:
- Reset, then mfc0 rd=12/13/14 → 32'h0000_0700 (NIRQ=3), 32'h0, 32'h0. rd=5 → 32'h0.
- mtc0 rd=12 wdata=32'h0000_0101, then syscall with in_next_pc=32'h0000_0104 → next cycle out_redirect=1, out_target=32'h0000_0800. Afterwards EPC=32'h104, Cause=32'h20, IE=0.
- eret after the syscall → one-cycle out_redirect with out_target=32'h104; IE=1.
- IE=1, IM=3'b111, raise in_irq[0] and in_irq[2] together, commit with in_next_pc=32'h200 → out_int_ack=3'b100, EPC=32'h200. After eret, irq0 is taken next with ack=3'b001.
- IE=0, raise in_irq[1] → IP bit9 set, no redirect. mtc0 rd=13 wdata=0 → IP cleared. Set IE=1 → still no redirect.
- in_valid=0 with in_syscall=1 → no state change. Assert in_rst_n=0 during REDIR → out_redirect drops asynchronously and all registers return to reset values.
